acc_frame_feeder: RTL

//  Upstream sequencer for the 4-bit accumulator (acc). Accepts one frame of

---
 rtl/acc_frame_feeder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/acc_frame_feeder.sv
// Frame sequencer for the DW-bit accumulator: clears it, feeds one frame of
// samples, then reports the captured sum, wrap count and a shadow-sum cross-check.
module acc_frame_feeder #(
  parameter int DW         = 4,
  parameter int LW         = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] frame_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          acc_clr,
  output logic [DW-1:0] acc_d,
  output logic          acc_step,
  input  logic [DW-1:0] acc_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [LW-1:0] res_wraps,
  output logic          res_err,
  output logic          busy
);

  localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t        state_r;
  logic [LW-1:0] len_r;
  logic [LW-1:0] cnt_r;
  logic [LW-1:0] wraps_r;
  logic [DW-1:0] shadow_r;
  logic [SW-1:0] settle_r;
  logic [DW:0]   sum_s;
  logic          accept_s;

  // Wrap counter sticks at all-ones rather than rolling over.
  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] w, input logic c);
    return (c && (w != {LW{1'b1}})) ? w + LW'(1) : w;
  endfunction

  assign in_ready = (state_r == RUN) && (cnt_r < len_r);
  assign accept_s = in_valid && in_ready;
  assign sum_s    = {1'b0, shadow_r} + {1'b0, in_data};
  assign busy     = (state_r != IDLE);

  // Frame sequencing FSM with registered acc strobes and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      len_r     <= '0;
      cnt_r     <= '0;
      wraps_r   <= '0;
      shadow_r  <= '0;
      settle_r  <= '0;
      acc_clr   <= 1'b0;
      acc_d     <= '0;
      acc_step  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_wraps <= '0;
      res_err   <= 1'b0;
    end else begin
      acc_clr  <= 1'b0;
      acc_step <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            len_r   <= frame_len;
            acc_clr <= 1'b1;
            state_r <= CLEAR;
          end
        end
        CLEAR: begin
          cnt_r    <= '0;
          shadow_r <= '0;
          wraps_r  <= '0;
          state_r  <= RUN;
        end
        RUN: begin
          if (accept_s) begin
            acc_d    <= in_data;
            acc_step <= 1'b1;
            cnt_r    <= cnt_r + LW'(1);
            shadow_r <= sum_s[DW-1:0];
            wraps_r  <= sat_inc(wraps_r, sum_s[DW]);
            if ((cnt_r + LW'(1)) == len_r) begin
              settle_r <= '0;
              state_r  <= SETTLE;
            end
          end
        end
        SETTLE: begin
          // The first SETTLE cycle carries the final acc_step; q is valid after that.
          if (settle_r == SW'(SETTLE_CYC)) begin
            res_data  <= acc_q;
            res_wraps <= wraps_r;
            res_err   <= (acc_q != shadow_r);
            res_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            settle_r <= settle_r + SW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
